btb_update_ctrl: RTL and testbench

Sequencer for the two-bank, 256-set branch target buffer (BTB) write path. It accepts update requests from the predecode stage and from the branch-resolve stage, then arbitrates between them. For each accepted request it performs a tag lookup on the shared BTB read port, yielding to fetch. It then writes the entry into the hit way, or into the LRU victim way, and maintains the per-set replacement state.

---
 rtl/btb_update_ctrl_pkg.sv | 50 +++++
 rtl/btb_update_ctrl_if.sv | 59 +++++
 rtl/btb_update_ctrl_arb.sv | 37 +++
 rtl/btb_update_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btb_update_ctrl_pkg.sv
// Shared definitions for the BTB update controller: entry field positions,
// PC tag/index slices, FSM state encodings and entry helpers.
// The FLUSH state exists only when BTB_UPD_FLUSH_EN is defined.
package btb_update_ctrl_pkg;

  localparam int ENTRY_W = 58;
  localparam int TAG_W   = 18;
  localparam int IDX_W   = 8;

  // Entry field positions.
  localparam int VALID_BIT = 57;
  localparam int TAG_HI    = 56;
  localparam int TAG_LO    = 39;
  localparam int CNT_HI    = 38;
  localparam int CNT_LO    = 35;
  localparam int TYPE_HI   = 34;
  localparam int TYPE_LO   = 32;
  localparam int TGT_HI    = 31;
  localparam int TGT_LO    = 0;

  // PC slices used for tag and set index.
  localparam int PC_TAG_HI = 30;
  localparam int PC_TAG_LO = 13;
  localparam int PC_IDX_HI = 12;
  localparam int PC_IDX_LO = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
`ifdef BTB_UPD_FLUSH_EN
    ST_WRITE  = 2'd2,
    ST_FLUSH  = 2'd3
`else
    ST_WRITE  = 2'd2
`endif
  } state_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [31:0] pc,
                                                    input logic [3:0]  cnt,
                                                    input logic [2:0]  typ,
                                                    input logic [31:0] tgt);
    return {1'b1, pc[PC_TAG_HI:PC_TAG_LO], cnt, typ, tgt};
  endfunction

  function automatic logic entry_hit(input logic [ENTRY_W-1:0] e,
                                     input logic [TAG_W-1:0]   tag);
    return e[VALID_BIT] && (e[TAG_HI:TAG_LO] == tag);
  endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Bus bundle between the BTB update controller (slave) and its environment:
// the two update requesters, fetch arbitration and the BTB array ports.
// Flush is only present when BTB_UPD_FLUSH_EN is defined.
interface btb_update_ctrl_if;
  import btb_update_ctrl_pkg::*;

  logic               PdUpValid;
  logic               PdUpReady;
  logic [31:0]        PdUpPc;
  logic [31:0]        PdUpTarget;
  logic [3:0]         PdUpCnt;
  logic [2:0]         PdUpType;

  logic               ExUpValid;
  logic               ExUpReady;
  logic [31:0]        ExUpPc;
  logic [31:0]        ExUpTarget;
  logic [3:0]         ExUpCnt;
  logic [2:0]         ExUpType;

  logic               FetchRdAble;
  logic               BtbRdReq;
  logic [IDX_W-1:0]   BtbRdIdx;
  logic [ENTRY_W-1:0] BtbRdData0;
  logic [ENTRY_W-1:0] BtbRdData1;

  logic               BtbWrEn0;
  logic               BtbWrEn1;
  logic [IDX_W-1:0]   BtbWrIdx;
  logic [ENTRY_W-1:0] BtbWrData;
  logic               Busy;

`ifdef BTB_UPD_FLUSH_EN
  logic               Flush;
`endif

  modport master (
`ifdef BTB_UPD_FLUSH_EN
    output Flush,
`endif
    output PdUpValid, PdUpPc, PdUpTarget, PdUpCnt, PdUpType,
    output ExUpValid, ExUpPc, ExUpTarget, ExUpCnt, ExUpType,
    output FetchRdAble, BtbRdData0, BtbRdData1,
    input  PdUpReady, ExUpReady, BtbRdReq, BtbRdIdx,
    input  BtbWrEn0, BtbWrEn1, BtbWrIdx, BtbWrData, Busy
  );

  modport slave (
`ifdef BTB_UPD_FLUSH_EN
    input  Flush,
`endif
    input  PdUpValid, PdUpPc, PdUpTarget, PdUpCnt, PdUpType,
    input  ExUpValid, ExUpPc, ExUpTarget, ExUpCnt, ExUpType,
    input  FetchRdAble, BtbRdData0, BtbRdData1,
    output PdUpReady, ExUpReady, BtbRdReq, BtbRdIdx,
    output BtbWrEn0, BtbWrEn1, BtbWrIdx, BtbWrData, Busy
  );

endinterface

// File: rtl/btb_update_ctrl_arb.sv
// btb_upd_arb: two-requester arbiter for BTB updates. Resolve wins by
// default; predecode is forced through after STARVE_MAX consecutive losses.
module btb_upd_arb
  import btb_update_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic pd_valid,
  input  logic ex_valid,
  output logic pd_grant,
  output logic ex_grant
);

  logic [1:0] starve_cnt;
  logic       pd_forced;

  // Grant decode; combinational on the valids so ready can follow valid.
  always_comb begin
    pd_forced = (starve_cnt == 2'(STARVE_MAX));
    pd_grant  = arb_en && pd_valid && (!ex_valid || pd_forced);
    ex_grant  = arb_en && ex_valid && !pd_grant;
  end

  // Count predecode losses; cleared whenever predecode is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en && pd_valid) begin
      if (pd_grant) starve_cnt <= '0;
      else          starve_cnt <= starve_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: BTB write-path sequencer. Accepts one update, looks up
// both banks on the shared read port (yielding to fetch), then rewrites the
// hit way or the LRU victim and flips that set's LRU bit.
// Optional: define BTB_UPD_FLUSH_EN to add the Flush input and FLUSH walk.
//
// state  | meaning
// IDLE   | arbitrate and capture the winning request
// LOOKUP | read both banks at the captured index when fetch allows
// WRITE  | registered write strobe active, LRU updated
// FLUSH  | clear both banks and LRU, one set per cycle (optional)
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int SETS       = 256,
  parameter int STARVE_MAX = 3
) (
  input logic              Clk,
  input logic              Rest,
  btb_update_ctrl_if.slave bus
);

  state_t             state;
  state_t             next_state;
  logic [31:0]        hold_pc;
  logic [31:0]        hold_tgt;
  logic [3:0]         hold_cnt;
  logic [2:0]         hold_type;
  logic [SETS-1:0]    lru;

  logic               arb_en;
  logic               flush_req;
  logic               pd_grant;
  logic               ex_grant;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit0;
  logic               hit1;
  logic               way_sel;
  logic               lookup_go;

  logic               wr_en0_q;
  logic               wr_en1_q;
  logic [IDX_W-1:0]   wr_idx_q;
  logic [ENTRY_W-1:0] wr_data_q;
  logic               wr_en0_d;
  logic               wr_en1_d;
  logic [IDX_W-1:0]   wr_idx_d;
  logic [ENTRY_W-1:0] wr_data_d;

`ifdef BTB_UPD_FLUSH_EN
  logic               flush_pend;

  // Remember a flush seen mid-operation so it runs on return to IDLE.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest)                                                      flush_pend <= 1'b0;
    else if (state == ST_IDLE)                                     flush_pend <= 1'b0;
    else if ((state == ST_LOOKUP || state == ST_WRITE) && bus.Flush) flush_pend <= 1'b1;
  end

  assign flush_req = bus.Flush || flush_pend;
`else
  assign flush_req = 1'b0;
`endif

  // Requests are only arbitrated in IDLE and a pending flush blocks them.
  assign arb_en = (state == ST_IDLE) && !flush_req;

  btb_upd_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk      (Clk),
    .rst      (Rest),
    .arb_en   (arb_en),
    .pd_valid (bus.PdUpValid),
    .ex_valid (bus.ExUpValid),
    .pd_grant (pd_grant),
    .ex_grant (ex_grant)
  );

  // FSM state register.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) state <= ST_IDLE;
    else      state <= next_state;
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
`ifdef BTB_UPD_FLUSH_EN
        if (flush_req) next_state = ST_FLUSH;
        else
`endif
        if (pd_grant || ex_grant) next_state = ST_LOOKUP;
      end
      ST_LOOKUP: if (!bus.FetchRdAble) next_state = ST_WRITE;
      ST_WRITE:  next_state = ST_IDLE;
`ifdef BTB_UPD_FLUSH_EN
      ST_FLUSH:  if (wr_idx_q == '1) next_state = ST_IDLE;
`endif
      default:   next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: read port, ready, busy and the registered write port.
  always_comb begin
    lookup_go     = (state == ST_LOOKUP) && !bus.FetchRdAble;
    bus.BtbRdReq  = lookup_go;
    bus.BtbRdIdx  = idx;
    bus.PdUpReady = pd_grant;
    bus.ExUpReady = ex_grant;
    bus.Busy      = (state != ST_IDLE);
    bus.BtbWrEn0  = wr_en0_q;
    bus.BtbWrEn1  = wr_en1_q;
    bus.BtbWrIdx  = wr_idx_q;
    bus.BtbWrData = wr_data_q;
  end

  // Capture the granted request; later input changes cannot disturb it.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      hold_pc   <= '0;
      hold_tgt  <= '0;
      hold_cnt  <= '0;
      hold_type <= '0;
    end else if (pd_grant) begin
      hold_pc   <= bus.PdUpPc;
      hold_tgt  <= bus.PdUpTarget;
      hold_cnt  <= bus.PdUpCnt;
      hold_type <= bus.PdUpType;
    end else if (ex_grant) begin
      hold_pc   <= bus.ExUpPc;
      hold_tgt  <= bus.ExUpTarget;
      hold_cnt  <= bus.ExUpCnt;
      hold_type <= bus.ExUpType;
    end
  end

  // Tag compare and way choice; bank0 wins a double hit, else LRU victim.
  always_comb begin
    idx  = hold_pc[PC_IDX_HI:PC_IDX_LO];
    tag  = hold_pc[PC_TAG_HI:PC_TAG_LO];
    hit0 = entry_hit(bus.BtbRdData0, tag);
    hit1 = entry_hit(bus.BtbRdData1, tag);
    if (hit0)      way_sel = 1'b0;
    else if (hit1) way_sel = 1'b1;
    else           way_sel = lru[idx];
  end

  // Next value of the write port; zero unless entering WRITE or FLUSH.
  always_comb begin
    wr_en0_d  = 1'b0;
    wr_en1_d  = 1'b0;
    wr_idx_d  = '0;
    wr_data_d = '0;
    if (lookup_go) begin
      wr_en0_d  = !way_sel;
      wr_en1_d  = way_sel;
      wr_idx_d  = idx;
      wr_data_d = make_entry(hold_pc, hold_cnt, hold_type, hold_tgt);
    end
`ifdef BTB_UPD_FLUSH_EN
    else if (next_state == ST_FLUSH) begin
      wr_en0_d = 1'b1;
      wr_en1_d = 1'b1;
      wr_idx_d = (state == ST_FLUSH) ? wr_idx_q + 8'd1 : '0;
    end
`endif
  end

  // Write-port registers; the write index doubles as the flush walker.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      wr_en0_q  <= 1'b0;
      wr_en1_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en0_q  <= wr_en0_d;
      wr_en1_q  <= wr_en1_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  // LRU points at the way not just written; flush clears it set by set.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      lru <= '0;
    end else if (state == ST_WRITE) begin
      lru[wr_idx_q] <= wr_en0_q;
    end
`ifdef BTB_UPD_FLUSH_EN
    else if (state == ST_FLUSH) begin
      lru[wr_idx_q] <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: stimulus pushes the expected write
// (strobe, index, entry, cycle) and a negedge monitor pops on every strobe.
// A behavioural two-bank BTB array answers the read port.
module tb_btb_update_ctrl;
  import btb_update_ctrl_pkg::*;

  typedef struct {
    logic        en0;
    logic        en1;
    logic [7:0]  idx;
    logic [57:0] data;
    int          cyc;
  } exp_t;

  logic Clk  = 1'b0;
  logic Rest = 1'b0;
  int   cyc  = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t e_mon;

  logic        mem_clr = 1'b0;
  logic        pre_en  = 1'b0;
  logic        pre_bank = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [57:0] pre_data = '0;
  logic [57:0] bank0 [256];
  logic [57:0] bank1 [256];

  btb_update_ctrl_if bus ();

  btb_update_ctrl #(.SETS(256), .STARVE_MAX(3)) dut (
    .Clk  (Clk),
    .Rest (Rest),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // BTB array model: combinational read, posedge write, bench preload port.
  always @(posedge Clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else begin
      if (bus.BtbWrEn0) bank0[bus.BtbWrIdx] <= bus.BtbWrData;
      if (bus.BtbWrEn1) bank1[bus.BtbWrIdx] <= bus.BtbWrData;
      if (pre_en) begin
        if (pre_bank) bank1[pre_idx] <= pre_data;
        else          bank0[pre_idx] <= pre_data;
      end
    end
  end
  assign bus.BtbRdData0 = bank0[bus.BtbRdIdx];
  assign bus.BtbRdData1 = bank1[bus.BtbRdIdx];

  // Monitor: every strobe must match the oldest expected write.
  always @(negedge Clk) begin
    if (bus.BtbWrEn0 || bus.BtbWrEn1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual en0=%b en1=%b idx=%h data=%h cyc=%0d required none",
                 bus.BtbWrEn0, bus.BtbWrEn1, bus.BtbWrIdx, bus.BtbWrData, cyc);
      end else begin
        e_mon = exp_q.pop_front();
        if (bus.BtbWrEn0 !== e_mon.en0 || bus.BtbWrEn1 !== e_mon.en1 ||
            bus.BtbWrIdx !== e_mon.idx || bus.BtbWrData !== e_mon.data || cyc != e_mon.cyc) begin
          failures++;
          $display("FAIL write actual en0=%b en1=%b idx=%h data=%h cyc=%0d required en0=%b en1=%b idx=%h data=%h cyc=%0d",
                   bus.BtbWrEn0, bus.BtbWrEn1, bus.BtbWrIdx, bus.BtbWrData, cyc,
                   e_mon.en0, e_mon.en1, e_mon.idx, e_mon.data, e_mon.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic bank, input logic [7:0] idx, input logic [17:0] tag,
                          input logic [3:0] cnt, input logic [2:0] typ, input logic [31:0] tgt,
                          input int wcyc);
    exp_t e;
    e.en0  = !bank;
    e.en1  = bank;
    e.idx  = idx;
    e.data = {1'b1, tag, cnt, typ, tgt};
    e.cyc  = wcyc;
    exp_q.push_back(e);
  endtask

  // Issue one request and wait for its accept; stall holds fetch on the port.
  task automatic send(input bit is_pd, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic [3:0] cnt, input logic [2:0] typ,
                      input logic [7:0] exp_idx, input logic [17:0] exp_tag,
                      input logic exp_bank, input int stall, input bit push,
                      output int t_acc);
    bit acc;
    acc   = 0;
    t_acc = -1;
    if (is_pd) begin
      bus.PdUpPc = pc; bus.PdUpTarget = tgt; bus.PdUpCnt = cnt; bus.PdUpType = typ;
      bus.PdUpValid = 1'b1;
    end else begin
      bus.ExUpPc = pc; bus.ExUpTarget = tgt; bus.ExUpCnt = cnt; bus.ExUpType = typ;
      bus.ExUpValid = 1'b1;
    end
    for (int k = 0; k < 400 && !acc; k++) begin
      #1;
      if (is_pd ? bus.PdUpReady : bus.ExUpReady) acc = 1;
      else @(negedge Clk);
    end
    if (!acc) begin
      failures++;
      checks++;
      $display("FAIL accept_timeout actual=no_ready required=ready pc=%h", pc);
      bus.PdUpValid = 1'b0;
      bus.ExUpValid = 1'b0;
      return;
    end
    t_acc = cyc;
    if (push) push_exp(exp_bank, exp_idx, exp_tag, cnt, typ, tgt, t_acc + 2 + stall);
    bus.FetchRdAble = (stall > 0);
    @(posedge Clk);
    #1;
    bus.PdUpValid = 1'b0;
    bus.ExUpValid = 1'b0;
    bus.PdUpPc = '1; bus.ExUpPc = '1; bus.PdUpTarget = '1; bus.ExUpTarget = '1;
    for (int s = 0; s < stall; s++) begin
      @(negedge Clk);
      chk("rdreq_during_fetch", {63'd0, bus.BtbRdReq}, 64'd0);
      @(posedge Clk);
      #1;
    end
    bus.FetchRdAble = 1'b0;
    if (push) begin
      @(negedge Clk);
      chk("rdreq_lookup", {63'd0, bus.BtbRdReq}, 64'd1);
      chk("rdidx_lookup", {56'd0, bus.BtbRdIdx}, {56'd0, exp_idx});
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (exp_q.size() == 0 && !bus.Busy) break;
    end
    if (k == 40) begin
      failures++;
      checks++;
      $display("FAIL drain_timeout actual pending=%0d busy=%b required pending=0 busy=0",
               exp_q.size(), bus.Busy);
    end
  endtask

  task automatic preload(input logic bank, input logic [7:0] idx, input logic [57:0] data);
    @(negedge Clk);
    pre_en = 1'b1; pre_bank = bank; pre_idx = idx; pre_data = data;
    @(posedge Clk);
    #1;
    pre_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1, t2, tf;
    int fstart;
    logic [7:0] exp_seq;
    bit got_pd, acc;

    bus.PdUpValid = 0; bus.PdUpPc = 0; bus.PdUpTarget = 0; bus.PdUpCnt = 0; bus.PdUpType = 0;
    bus.ExUpValid = 0; bus.ExUpPc = 0; bus.ExUpTarget = 0; bus.ExUpCnt = 0; bus.ExUpType = 0;
    bus.FetchRdAble = 0;
`ifdef BTB_UPD_FLUSH_EN
    bus.Flush = 0;
`endif
    mem_clr = 1'b1;
    #1 Rest = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_busy",    {63'd0, bus.Busy},     64'd0);
    chk("reset_rdreq",   {63'd0, bus.BtbRdReq}, 64'd0);
    chk("reset_wren",    {62'd0, bus.BtbWrEn1, bus.BtbWrEn0}, 64'd0);
    chk("reset_wridx",   {56'd0, bus.BtbWrIdx}, 64'd0);
    chk("reset_wrdata",  {6'd0, bus.BtbWrData}, 64'd0);
    chk("reset_rdidx",   {56'd0, bus.BtbRdIdx}, 64'd0);
    mem_clr = 1'b0;
    @(negedge Clk);
    Rest = 1'b0;
    @(negedge Clk);

    // Cold miss -> bank0, set 0x82, tag 0; then same set accepted at T+3 hits bank0.
    send(0, 32'h0000_1040, 32'h0000_2000, 4'd4, 3'd1, 8'h82, 18'h0, 1'b0, 0, 1, t1);
    send(0, 32'h0000_1040, 32'h0000_2222, 4'd5, 3'd2, 8'h82, 18'h0, 1'b0, 0, 1, t2);
    chk("back_to_back_accept", 64'(t2), 64'(t1 + 3));
    // New tag in set 0x82: miss, LRU is 1 after the bank0 write -> bank1.
    send(0, 32'h0000_3040, 32'h0000_4444, 4'd1, 3'd3, 8'h82, 18'h1, 1'b1, 0, 1, t1);
    drain();

    // Hit update in bank1 with bank0 invalid.
    preload(1'b0, 8'h82, 58'd0);
    preload(1'b1, 8'h82, {1'b1, 18'h0, 4'h7, 3'h1, 32'h0000_1111});
    send(0, 32'h0000_1040, 32'h0000_3000, 4'd6, 3'd1, 8'h82, 18'h0, 1'b1, 0, 1, t1);
    // Miss after the bank1 write: LRU is 0 -> bank0.
    send(0, 32'h0000_5040, 32'h0000_5555, 4'd2, 3'd4, 8'h82, 18'h2, 1'b0, 0, 1, t1);
    drain();

    // Fetch owns the read port for 4 LOOKUP cycles: write lands at T+6.
    send(1, 32'h0000_0200, 32'h0000_6000, 4'd3, 3'd5, 8'h10, 18'h0, 1'b0, 4, 1, t1);
    drain();

    // Reset during LOOKUP: the write is dropped and LRU clears.
    send(0, 32'h0000_0400, 32'h0000_7000, 4'd9, 3'd6, 8'h20, 18'h0, 1'b0, 0, 1, t1);
    drain();
    send(0, 32'h0000_2400, 32'h0000_7100, 4'd10, 3'd2, 8'h20, 18'h1, 1'b1, 0, 0, t1);
    Rest = 1'b1;
    #1;
    chk("abort_busy", {63'd0, bus.Busy}, 64'd0);
    chk("abort_wren", {62'd0, bus.BtbWrEn1, bus.BtbWrEn0}, 64'd0);
    @(negedge Clk);
    Rest = 1'b0;
    repeat (3) @(negedge Clk);
    send(0, 32'h0000_2400, 32'h0000_7200, 4'd11, 3'd3, 8'h20, 18'h1, 1'b0, 0, 1, t1);
    drain();

    // Starvation: both requesters valid continuously.
    exp_seq = 8'b1000_1000;
    bus.ExUpPc = 32'h0000_2100; bus.ExUpTarget = 32'h0000_8000; bus.ExUpCnt = 4'd1; bus.ExUpType = 3'd1;
    bus.PdUpPc = 32'h0000_4060; bus.PdUpTarget = 32'h0000_9000; bus.PdUpCnt = 4'd2; bus.PdUpType = 3'd2;
    bus.ExUpValid = 1'b1;
    bus.PdUpValid = 1'b1;
    for (int g = 0; g < 8; g++) begin
      acc = 0;
      for (int k = 0; k < 10 && !acc; k++) begin
        #1;
        if (bus.PdUpReady || bus.ExUpReady) begin
          acc = 1;
          got_pd = bus.PdUpReady;
          chk("grant_seq", {63'd0, got_pd}, {63'd0, exp_seq[g]});
          chk("ready_onehot", {63'd0, bus.PdUpReady && bus.ExUpReady}, 64'd0);
          if (got_pd) push_exp(1'b0, 8'h03, 18'h2, 4'd2, 3'd2, 32'h0000_9000, cyc + 2);
          else        push_exp(1'b0, 8'h08, 18'h1, 4'd1, 3'd1, 32'h0000_8000, cyc + 2);
        end
        @(negedge Clk);
      end
      if (!acc) begin
        failures++;
        checks++;
        $display("FAIL starve_accept_timeout actual=no_ready required=ready grant=%0d", g);
      end
    end
    @(posedge Clk);
    #1;
    bus.ExUpValid = 1'b0;
    bus.PdUpValid = 1'b0;
    drain();

`ifdef BTB_UPD_FLUSH_EN
    // Flush with a resolve request pending: 256 dual-bank clears, then accept.
    @(negedge Clk);
    #1;
    fstart = cyc;
    bus.Flush = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp_t e;
      e.en0 = 1'b1; e.en1 = 1'b1; e.idx = 8'(i); e.data = '0; e.cyc = fstart + 1 + i;
      exp_q.push_back(e);
    end
    fork
      begin
        @(posedge Clk);
        #1;
        bus.Flush = 1'b0;
      end
    join_none
    send(0, 32'h0000_1040, 32'h0000_7777, 4'd8, 3'd7, 8'h82, 18'h0, 1'b0, 0, 1, tf);
    chk("flush_accept_cycle", 64'(tf), 64'(fstart + 257));
    drain();
`endif

    repeat (2) @(negedge Clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
